systolic_feeder: RTL and testbench

Front-end driver for the N×N output-stationary systolic multiplication array. It accepts two N×N operand matrices row by row over a valid/ready load port and stores them locally. It then clears the array and emits the diagonally skewed, zero-padded wavefronts on the array's a/b lane inputs. After the array has drained, it signals completion, replacing hand-built skewed stimulus.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_lane_sel.sv | 25 ++
 rtl/systolic_feeder.sv | 148 ++++++++++++++
 tb/tb_systolic_feeder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, default
// sizing and lane-slice macro for the feeder.
`ifndef SYSTOLIC_PKG_SV
`define SYSTOLIC_PKG_SV

`define SYS_LANE(v, i, w) v[(i)*(w) +: (w)]

package systolic_pkg;

  localparam int N_DEF  = 6;
  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`endif

// File: rtl/skew_lane_sel.sv
// skew_lane_sel: picks element t-lane of a stored
// row/column, or zero outside the wavefront.
module skew_lane_sel
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 4
) (
  input  logic [CW-1:0]   lane,
  input  logic [CW-1:0]   t,
  input  logic [N*DW-1:0] vec,
  output logic [DW-1:0]   op
);

  logic [CW-1:0] k;

  always_comb begin
    k  = t - lane;
    op = '0;
    if (t >= lane && k < CW'(N))
      op = `SYS_LANE(vec, k, DW);
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads A and B row by row, then
// drives skewed wavefronts into the systolic array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [N*DW-1:0] ld_data,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic          arr_clr,
  output logic          feed_active,
  output logic          done
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_BEAT = CW'(2*N-1);
  localparam logic [CW-1:0] LAST_FEED = CW'(2*N-2);
  localparam logic [CW-1:0] LAST_DRN  = CW'(N-1);

  state_t        st, st_n;
  logic [CW-1:0] beat, beat_n;
  logic [CW-1:0] t, t_n;
  logic          acc;

  // rows 0..N-1 hold A, rows N..2N-1 hold B
  logic [N*DW-1:0] mem [2*N];
  logic [N*DW-1:0] a_sel, b_sel;

  assign acc = (st == S_LOAD) && ld_valid;

  always_comb begin
    st_n   = st;
    beat_n = beat;
    t_n    = t;
    unique case (st)
      S_LOAD: begin
        if (acc) begin
          if (beat == LAST_BEAT) begin
            st_n   = S_CLEAR;
            beat_n = '0;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        st_n = S_FEED;
        t_n  = '0;
      end
      S_FEED: begin
        if (t == LAST_FEED) begin
          st_n = S_DRAIN;
          t_n  = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (t == LAST_DRN) begin
          st_n = S_DONE;
          t_n  = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      S_DONE: begin
        st_n   = S_LOAD;
        t_n    = '0;
        beat_n = '0;
      end
      default: st_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_LOAD;
      beat <= '0;
      t    <= '0;
    end else begin
      st   <= st_n;
      beat <= beat_n;
      t    <= t_n;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      mem[beat] <= ld_data;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N*DW-1:0] col;
    for (genvar r = 0; r < N; r++) begin : g_col
      assign `SYS_LANE(col, r, DW) =
        `SYS_LANE(mem[N+r], i, DW);
    end

    skew_lane_sel #(
      .N (N),
      .DW(DW),
      .CW(CW)
    ) u_a (
      .lane(CW'(i)),
      .t   (t_n),
      .vec (mem[i]),
      .op  (`SYS_LANE(a_sel, i, DW))
    );

    skew_lane_sel #(
      .N (N),
      .DW(DW),
      .CW(CW)
    ) u_b (
      .lane(CW'(i)),
      .t   (t_n),
      .vec (col),
      .op  (`SYS_LANE(b_sel, i, DW))
    );
  end

  // outputs follow the next state so they line
  // up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ready    <= 1'b1;
      arr_clr     <= 1'b0;
      feed_active <= 1'b0;
      done        <= 1'b0;
      a_out       <= '0;
      b_out       <= '0;
    end else begin
      ld_ready    <= st_n == S_LOAD;
      arr_clr     <= st_n == S_CLEAR;
      feed_active <= st_n == S_FEED;
      done        <= st_n == S_DONE;
      a_out <= (st_n == S_FEED) ? a_sel : '0;
      b_out <= (st_n == S_FEED) ? b_sel : '0;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed table checks on an
// N=2 feeder plus an N=6 run into an array model.
module tb_systolic_feeder;

  localparam int DW = 32;

  typedef struct packed {
    logic          clr;
    logic          fa;
    logic          dn;
    logic          rdy;
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         v2, r2, clr2, fa2, dn2;
  logic [63:0]  d2, a2, b2;
  logic         v6, r6, clr6, fa6, dn6;
  logic [191:0] d6, a6, b6;

  systolic_feeder #(.N(2), .DW(DW)) dut2 (
    .clk(clk), .rst(rst),
    .ld_valid(v2), .ld_ready(r2), .ld_data(d2),
    .a_out(a2), .b_out(b2),
    .arr_clr(clr2), .feed_active(fa2), .done(dn2)
  );

  systolic_feeder #(.N(6), .DW(DW)) dut6 (
    .clk(clk), .rst(rst),
    .ld_valid(v6), .ld_ready(r6), .ld_data(d6),
    .a_out(a6), .b_out(b6),
    .arr_clr(clr6), .feed_active(fa6), .done(dn6)
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm,
                     input logic [191:0] act,
                     input logic [191:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic c, logic f,
                              logic d, logic r,
                              int x0, int x1,
                              int y0, int y1);
    return '{c, f, d, r, x0, x1, y0, y1};
  endfunction

  function automatic vec_t cur2();
    return '{clr2, fa2, dn2, r2,
             a2[31:0], a2[63:32],
             b2[31:0], b2[63:32]};
  endfunction

  // output-stationary array model on the N=6 lanes
  logic [31:0] cacc [6][6];
  logic [31:0] ah   [6][6];
  logic [31:0] bh   [6][6];

  function automatic logic [31:0] ain(int i, int j);
    if (j == 0) return a6[i*32 +: 32];
    return ah[i][j-1];
  endfunction

  function automatic logic [31:0] bin(int i, int j);
    if (i == 0) return b6[j*32 +: 32];
    return bh[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        if (clr6) begin
          cacc[i][j] <= '0;
          ah[i][j]   <= '0;
          bh[i][j]   <= '0;
        end else begin
          cacc[i][j] <= cacc[i][j] + ain(i, j) * bin(i, j);
          ah[i][j]   <= ain(i, j);
          bh[i][j]   <= bin(i, j);
        end
      end
    end
  end

  task automatic load2(input logic [63:0] rows [4],
                       input int first, input int upto,
                       input bit stall);
    int k = first;
    int g = 0;
    bit ph = 1'b1;
    logic rdy;
    while (k < upto && g < 40) begin
      v2 = stall ? ph : 1'b1;
      d2 = rows[k];
      @(negedge clk);
      rdy = r2;
      @(posedge clk); #1;
      if (v2 && rdy) k++;
      ph = !ph;
      g++;
    end
    v2 = 1'b0;
    chk("load2_beats", 192'(k), 192'(upto));
  endtask

  task automatic run2(input string nm, input vec_t exp [8],
                      input bit junk, input bit chain,
                      input logic [63:0] nrow);
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        v2 = junk;
        d2 = 64'hdead_beef_cafe_f00d;
      end else begin
        v2 = chain;
        d2 = nrow;
      end
      @(negedge clk);
      chk($sformatf("%s_L+%0d", nm, c + 1),
          192'(cur2()), 192'(exp[c]));
      @(posedge clk); #1;
    end
    if (!chain) v2 = 1'b0;
  endtask

  task automatic load6(input logic [191:0] rows [12],
                       input int upto);
    int k = 0;
    int g = 0;
    logic rdy;
    while (k < upto && g < 60) begin
      v6 = 1'b1;
      d6 = rows[k];
      @(negedge clk);
      rdy = r6;
      @(posedge clk); #1;
      if (rdy) k++;
      g++;
    end
    v6 = 1'b0;
    chk("load6_beats", 192'(k), 192'(upto));
  endtask

  vec_t         t1 [8];
  vec_t         t2 [8];
  logic [63:0]  m1 [4];
  logic [63:0]  m2 [4];
  logic [191:0] good [12];
  logic [191:0] junk [12];
  vec_t         vrst;

  initial begin
    int k;
    int act;
    bit found;

    m1[0] = {32'd2, 32'd1};
    m1[1] = {32'd4, 32'd3};
    m1[2] = {32'd6, 32'd5};
    m1[3] = {32'd8, 32'd7};
    m2[0] = {32'd10, 32'd9};
    m2[1] = {32'd12, 32'd11};
    m2[2] = {32'd14, 32'd13};
    m2[3] = {32'd16, 32'd15};

    t1[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    t1[1] = mk(0, 1, 0, 0, 1, 0, 5, 0);
    t1[2] = mk(0, 1, 0, 0, 2, 3, 7, 6);
    t1[3] = mk(0, 1, 0, 0, 0, 4, 0, 8);
    t1[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    t1[5] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    t1[6] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    t1[7] = mk(0, 0, 0, 1, 0, 0, 0, 0);

    t2[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    t2[1] = mk(0, 1, 0, 0, 9, 0, 13, 0);
    t2[2] = mk(0, 1, 0, 0, 10, 11, 15, 14);
    t2[3] = mk(0, 1, 0, 0, 0, 12, 0, 16);
    t2[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    t2[5] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    t2[6] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    t2[7] = mk(0, 0, 0, 1, 0, 0, 0, 0);

    vrst = mk(0, 0, 0, 1, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        good[r][c*32 +: 32]   = (r == c) ? 32'd1 : 32'd0;
        good[6+r][c*32 +: 32] = 32'(6*r + c);
        junk[r][c*32 +: 32]   = 32'(10*r + c + 1);
        junk[6+r][c*32 +: 32] = 32'(100 + 10*r + c);
      end
    end

    v2 = 1'b0; d2 = '0;
    v6 = 1'b0; d6 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst2", 192'(cur2()), 192'(vrst));
    chk("rst6_ctl", 192'({r6, clr6, fa6, dn6}), 192'(4'b1000));
    chk("rst6_a", a6, '0);
    chk("rst6_b", b6, '0);
    @(posedge clk); #1;

    load2(m1, 0, 4, 1'b0);
    run2("plain", t1, 1'b0, 1'b0, '0);

    load2(m1, 0, 4, 1'b1);
    run2("stall", t1, 1'b0, 1'b0, '0);

    load2(m2, 0, 4, 1'b0);
    run2("junk", t2, 1'b1, 1'b0, '0);

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_after", 192'({clr2, fa2, r2}), 192'(3'b001));
      @(posedge clk); #1;
    end

    load2(m1, 0, 3, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("part_load", 192'({clr2, fa2, r2}), 192'(3'b001));
      @(posedge clk); #1;
    end
    load2(m1, 3, 4, 1'b0);
    run2("b2b1", t1, 1'b0, 1'b1, m2[0]);
    load2(m2, 1, 4, 1'b0);
    run2("b2b2", t2, 1'b0, 1'b0, '0);

    load6(junk, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    load6(junk, 12);
    chk("n6_clr", 192'(clr6), 192'(1'b1));
    repeat (4) @(posedge clk);
    #1;
    chk("n6_t3_a",
        192'({a6[0 +: 32], a6[96 +: 32], a6[128 +: 32]}),
        192'({32'd4, 32'd31, 32'd0}));
    chk("n6_t3_b", 192'(b6[32 +: 32]), 192'(32'd121));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctl", 192'({r6, clr6, fa6, dn6}), 192'(4'b1000));
    chk("abort_a", a6, '0);
    chk("abort_b", b6, '0);
    act = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (dn6 || fa6 || clr6) act++;
    end
    chk("abort_quiet", 192'(act), 192'(0));
    @(posedge clk); #1;

    load6(good, 12);
    k = 1;
    found = 1'b0;
    while (k < 40 && !found) begin
      @(negedge clk);
      if (dn6) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("n6_done_cycle", 192'(k), 192'(19));
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        chk($sformatf("n6_c%0d%0d", i, j),
            192'(cacc[i][j]), 192'(6*i + j));
      end
    end
    @(posedge clk); #1;
    chk("n6_ready", 192'(r6), 192'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
